// File: rtl/sw_ctrl_pkg.sv
// Shared constants and types for the switch-bank conditioning front end.
// Switch roles, debounce depth and the debounce history type live here, with
// a helper that builds the divider compare mask for a given divide exponent.
package sw_ctrl_pkg;

   localparam int SW_STEP_IDX  = 1;    // PC-advance request switch
   localparam int SW_WB_IDX    = 2;    // register-file write switch
   localparam int SW_SPEED_IDX = 15;   // CPU tick rate select switch
   localparam int DB_DEPTH     = 3;    // consecutive agreeing samples to change level

   typedef logic [DB_DEPTH-1:0] db_hist_t;

   localparam db_hist_t DB_ALL_ONES  = '1;
   localparam db_hist_t DB_ALL_ZEROS = '0;

   // Mask covering cnt[div:0]; a tick fires when those bits are all ones.
   function automatic logic [31:0] div_mask(input int div);
      return 32'((64'd1 << (div + 1)) - 64'd1);
   endfunction

endpackage

// File: rtl/sw_db_cell.sv
// One conditioned switch: two-flop synchroniser, sample history and the
// debounced level. The level only moves once DB_DEPTH consecutive samples
// agree, so any disturbance shorter than that never reaches the output.
module sw_db_cell
   import sw_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic i_strobe,   // shared sample strobe from the top
   input  logic i_sw,       // raw switch level, asynchronous to clk
   output logic o_db        // debounced level
);

   logic     r_sync0;
   logic     r_sync1;
   db_hist_t r_hist;
   logic     r_db;
   db_hist_t w_hist_next;

   assign w_hist_next = {r_hist[DB_DEPTH-2:0], r_sync1};

   // Bring the raw level into the clk domain through two flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync0 <= 1'b0;
         r_sync1 <= 1'b0;
      end else begin
         r_sync0 <= i_sw;
         r_sync1 <= r_sync0;
      end
   end

   // On each strobe shift in a sample; change level only on a unanimous history.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_hist <= DB_ALL_ZEROS;
         r_db   <= 1'b0;
      end else if (i_strobe) begin
         r_hist <= w_hist_next;
         if (w_hist_next == DB_ALL_ONES) begin
            r_db <= 1'b1;
         end else if (w_hist_next == DB_ALL_ZEROS) begin
            r_db <= 1'b0;
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/sw_step_ctrl.sv
// Switch-bank front end for the single-cycle CPU top.
// Debounces all switches with a shared sample strobe, turns the step and
// register-write switches into single-clk pulses, and produces a free-running
// CPU tick enable whose rate is picked by the speed switch. No derived clocks.
// Optional build macro: STEP_AUTOREPEAT_EN -- while the step switch is held,
// step_pulse_o also fires on every tick after the initial edge pulse.
// N_SW must be large enough to cover SW_SPEED_IDX.
module sw_step_ctrl
   import sw_ctrl_pkg::*;
#(
   parameter int N_SW      = 16,
   parameter int DB_CYCLES = 1000000,
   parameter int FAST_DIV  = 25,
   parameter int SLOW_DIV  = 27
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N_SW-1:0] sw_i,
   output logic [N_SW-1:0] sw_db_o,
   output logic            step_pulse_o,
   output logic            wb_pulse_o,
   output logic            tick_o
);

   localparam int               SMP_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(DB_CYCLES - 1);
   localparam logic [31:0]      FAST_MASK = div_mask(FAST_DIV);
   localparam logic [31:0]      SLOW_MASK = div_mask(SLOW_DIV);

   logic [SMP_W-1:0] r_smp_cnt;
   logic             w_strobe;
   logic [N_SW-1:0]  w_sw_db;

   logic             r_step_dly;
   logic             r_wb_dly;
   logic             r_step;
   logic             r_wb;
   logic             w_step_rise;
   logic             w_wb_rise;
   logic             w_step_fire;

   logic [31:0]      r_div_cnt;
   logic [31:0]      w_div_mask;
   logic             w_tick_hit;
   logic             r_tick;

   // Sample counter: one strobe every DB_CYCLES clocks, shared by all cells.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_smp_cnt <= '0;
      end else if (r_smp_cnt == SMP_LAST) begin
         r_smp_cnt <= '0;
      end else begin
         r_smp_cnt <= r_smp_cnt + 1'b1;
      end
   end

   assign w_strobe = (r_smp_cnt == SMP_LAST);

   genvar gi;
   generate
      for (gi = 0; gi < N_SW; gi++) begin : g_cell
         sw_db_cell u_cell (
            .clk      (clk),
            .rstn     (rstn),
            .i_strobe (w_strobe),
            .i_sw     (sw_i[gi]),
            .o_db     (w_sw_db[gi])
         );
      end
   endgenerate

   assign sw_db_o = w_sw_db;

   // Divider: free-running 32-bit count; the speed switch picks how many low bits must be ones.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 32'd1;
      end
   end

   // Low bit of the count toggles every clk, so the hit can never last two cycles,
   // and a rate change simply waits for the new field to fill with ones.
   assign w_div_mask = w_sw_db[SW_SPEED_IDX] ? SLOW_MASK : FAST_MASK;
   assign w_tick_hit = ((r_div_cnt & w_div_mask) == w_div_mask);

   assign w_step_rise = w_sw_db[SW_STEP_IDX] & ~r_step_dly;
   assign w_wb_rise   = w_sw_db[SW_WB_IDX]   & ~r_wb_dly;

`ifdef STEP_AUTOREPEAT_EN
   // Held step switch repeats at the tick rate; edge and tick together give one pulse.
   assign w_step_fire = w_step_rise | (w_sw_db[SW_STEP_IDX] & w_tick_hit);
`else
   assign w_step_fire = w_step_rise;
`endif

   // Edge detectors and registered output pulses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_step_dly <= 1'b0;
         r_wb_dly   <= 1'b0;
         r_step     <= 1'b0;
         r_wb       <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_step_dly <= w_sw_db[SW_STEP_IDX];
         r_wb_dly   <= w_sw_db[SW_WB_IDX];
         r_step     <= w_step_fire;
         r_wb       <= w_wb_rise;
         r_tick     <= w_tick_hit;
      end
   end

   assign step_pulse_o = r_step;
   assign wb_pulse_o   = r_wb;
   assign tick_o       = r_tick;

endmodule

// File: tb/tb_sw_step_ctrl.sv
// Directed bench for sw_step_ctrl with DB_CYCLES=4, FAST_DIV=3, SLOW_DIV=5.
// Outputs are sampled 1 time unit after each rising edge; a per-cycle
// accumulator gathers pulse counts and tick spacing for each phase.
module tb_sw_step_ctrl;

`ifdef STEP_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic        clk;
   logic        rstn;
   logic [15:0] sw_i;
   logic [15:0] sw_db_o;
   logic        step_pulse_o;
   logic        wb_pulse_o;
   logic        tick_o;

   int n_checks = 0;
   int n_fail   = 0;

   // per-phase accumulators
   int cyc        = 0;
   int acc_step   = 0;
   int acc_wb     = 0;
   int acc_tick   = 0;
   int exp_step   = 0;
   int first_step = -1;
   int first_wb   = -1;
   int last_tick  = -1;
   int last_int   = 0;
   int min_int    = 1000000;
   bit tick_wide  = 0;
   bit prev_tick  = 0;
   bit db3_seen   = 0;
   bit db1_p      = 0;
   bit db1_pp     = 0;

   sw_step_ctrl #(
      .N_SW      (16),
      .DB_CYCLES (4),
      .FAST_DIV  (3),
      .SLOW_DIV  (5)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .sw_i         (sw_i),
      .sw_db_o      (sw_db_o),
      .step_pulse_o (step_pulse_o),
      .wb_pulse_o   (wb_pulse_o),
      .tick_o       (tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic reset_acc();
      acc_step   = 0;
      acc_wb     = 0;
      acc_tick   = 0;
      exp_step   = 0;
      first_step = -1;
      first_wb   = -1;
      last_tick  = -1;
      last_int   = 0;
      min_int    = 1000000;
      tick_wide  = 0;
      db3_seen   = 0;
   endtask

   // Advance one clock and accumulate what the outputs did in that cycle.
   task automatic clk1();
      @(posedge clk);
      #1;
      cyc++;
      if (step_pulse_o) begin
         acc_step++;
         if (first_step < 0) first_step = cyc;
      end
      if (wb_pulse_o) begin
         acc_wb++;
         if (first_wb < 0) first_wb = cyc;
      end
      if (tick_o) begin
         acc_tick++;
         if (prev_tick) tick_wide = 1;
         if (last_tick >= 0) begin
            last_int = cyc - last_tick;
            if (last_int < min_int) min_int = last_int;
         end
         last_tick = cyc;
      end
      prev_tick = tick_o;
      if (sw_db_o[3]) db3_seen = 1;
      // expected step pulse: rising debounced level one cycle earlier,
      // plus (auto-repeat builds) any tick while the level was already high
      if ((db1_p && !db1_pp) || (AR && db1_p && tick_o)) exp_step++;
      db1_pp = db1_p;
      db1_p  = sw_db_o[1];
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) clk1();
   endtask

   // Wait (bounded) for a debounced bit to reach a level; lat=-1 on timeout.
   task automatic wait_db(input int idx, input logic val, input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         clk1();
         if (sw_db_o[idx] == val) begin
            lat = i;
            break;
         end
      end
   endtask

   function automatic int step_exp(input int hand);
      return AR ? exp_step : hand;
   endfunction

   initial begin
      int lat;
      int rise_cyc;

      rstn = 1'b0;
      sw_i = '0;
      #23;
      chk("rst_sw_db", 32'(sw_db_o), 32'd0);
      chk("rst_step", 32'(step_pulse_o), 32'd0);
      chk("rst_wb", 32'(wb_pulse_o), 32'd0);
      chk("rst_tick", 32'(tick_o), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // idle: tick every 16 clk, everything else quiet
      reset_acc();
      run(64);
      chk("idle_tick_count", 32'(acc_tick), 32'd4);
      chk("idle_tick_period", 32'(last_int), 32'd16);
      chk("idle_tick_width", 32'(tick_wide), 32'd0);
      chk("idle_step", 32'(acc_step), 32'd0);
      chk("idle_wb", 32'(acc_wb), 32'd0);
      chk("idle_sw_db", 32'(sw_db_o), 32'd0);

      // step switch rises and is held
      reset_acc();
      sw_i[1] = 1'b1;
      wait_db(1, 1'b1, 20, lat);
      rise_cyc = cyc;
      chk("step_db_latency_ok", 32'((lat >= 11) && (lat <= 14)), 32'd1);
      run(40);
      chk("step_pulse_count", 32'(acc_step), 32'(step_exp(1)));
      chk("step_pulse_cycle", 32'(first_step), 32'(rise_cyc + 1));
      chk("step_no_wb", 32'(acc_wb), 32'd0);

      // step switch released: no pulse on the falling edge
      reset_acc();
      sw_i[1] = 1'b0;
      wait_db(1, 1'b0, 20, lat);
      chk("step_fall_latency_ok", 32'((lat >= 11) && (lat <= 14)), 32'd1);
      run(10);
      chk("step_fall_pulses", 32'(acc_step), 32'(step_exp(0)));

      // glitch on sw[3] lasting two strobe periods never propagates
      reset_acc();
      sw_i[3] = 1'b1;
      run(8);
      sw_i[3] = 1'b0;
      run(30);
      chk("glitch_sw3_db", 32'(db3_seen), 32'd0);

      // step and write switches rise together
      reset_acc();
      sw_i[2:1] = 2'b11;
      run(30);
      chk("dual_step_count", 32'(acc_step), 32'(step_exp(1)));
      chk("dual_wb_count", 32'(acc_wb), 32'd1);
      chk("dual_same_cycle", 32'(first_step == first_wb), 32'd1);
      chk("dual_pulse_seen", 32'(first_wb > 0), 32'd1);
      sw_i[2:1] = 2'b00;
      run(30);

      // speed switch: period 16 -> 64 with no double or wide tick
      reset_acc();
      sw_i[15] = 1'b1;
      run(200);
      chk("speed_db", 32'(sw_db_o[15]), 32'd1);
      chk("speed_tick_width", 32'(tick_wide), 32'd0);
      chk("speed_min_interval_ok", 32'(min_int >= 16), 32'd1);
      chk("speed_tick_period", 32'(last_int), 32'd64);

      // one-clock reset in the middle of a step debounce
      sw_i[1] = 1'b1;
      run(9);
      rstn = 1'b0;
      #2;
      chk("midrst_sw_db", 32'(sw_db_o), 32'd0);
      chk("midrst_step", 32'(step_pulse_o), 32'd0);
      chk("midrst_tick", 32'(tick_o), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rstn   = 1'b1;
      db1_p  = 0;
      db1_pp = 0;
      prev_tick = 0;
      reset_acc();
      wait_db(1, 1'b1, 20, lat);
      rise_cyc = cyc;
      chk("midrst_reassert_latency", 32'(lat), 32'd12);
      run(30);
      chk("midrst_step_count", 32'(acc_step), 32'(step_exp(1)));
      chk("midrst_step_cycle", 32'(first_step), 32'(rise_cyc + 1));
      chk("midrst_speed_db", 32'(sw_db_o[15]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
